mem_wb_load_unit: RTL and testbench
===================================

// Module: mem_wb_load_unit
// PURPOSE
//  WB-stage consumer of the MEM->WB register fields on the pro pipe. Accepts one
//  instruction per cycle; ALU ops pass straight to writeback, loads wait for the
//  D-cache/uncached read response, then align, extend or merge (LWL/LWR) it into the GPR write data.
//  Raises stall_req upstream while a load response is outstanding.
// PARAMETERS
//  (none)
// PORTS
//  clk            in   1   clock, rising edge
//  aresetn        in   1   asynchronous reset, active low
//  flush          in   1   kill the in-flight instruction (exception/redirect)
//  in_valid       in   1   MEM->WB fields below valid this cycle
//  in_wRegEn      in   1   GPR write enable
//  in_wRegAddr    in   5   GPR destination
//  in_aluAns      in   32  ALU result / load byte address
//  in_rwmem       in   1   1 = load awaiting read data
//  in_rsize       in   3   3'd1 byte, 3'd2 half, 3'd4 word
//  in_signExt     in   1   sign-extend byte/half
//  in_left_right  in   2   2'b00 normal, 2'b01 LWL, 2'b10 LWR
//  in_rtReg       in   32  old rt value for LWL/LWR merge
//  in_pc          in   32  instruction PC
//  rdata_valid    in   1   read response strobe (1 cycle)
//  rdata          in   32  read data word, little-endian
//  stall_req      out  1   1 = hold MEM->WB register (in_* not accepted)
//  wb_valid       out  1   writeback fields valid (1 cycle)
//  wb_wRegEn      out  1   GPR write enable
//  wb_wRegAddr    out  5   GPR address
//  wb_wData       out  32  GPR write data
//  wb_pc          out  32  PC of written-back instruction
// BEHAVIOUR
//  Reset (aresetn=0, async): state=IDLE; stall_req, wb_valid, wb_wRegEn=0; wb_wRegAddr,
//   wb_wData, wb_pc=0; captured fields=0.
//  States: IDLE, WAIT, DRAIN. stall_req = (state!=IDLE), combinational from state.
//  IDLE: accept when in_valid & ~flush.
//   in_rwmem=0 -> next cycle wb_valid=1, wb_wData=in_aluAns, other wb_* from in_*.
//   in_rwmem=1 -> capture addr/rsize/signExt/left_right/rtReg/wRegEn/wRegAddr/pc; -> WAIT.
//  WAIT: stall_req=1. rdata_valid -> next cycle wb_valid=1, wb_wData=align(rdata), -> IDLE.
//   flush without rdata_valid -> DRAIN (response still owed). flush with rdata_valid -> IDLE, no wb.
//  DRAIN: stall_req=1; rdata_valid -> discard, -> IDLE. flush ignored.
//  rdata_valid in IDLE is ignored. Response never arrives in the acceptance cycle.
//  wb_valid=0 in all other cycles; wb_wRegEn = captured wRegEn & wb_valid.
//  align(): off = addr[1:0].
//   byte: b=rdata[8*off+:8]; ext = signExt ? {{24{b[7]}},b} : {24'b0,b}.
//   half: h = off[1] ? rdata[31:16] : rdata[15:0]; off[0] ignored; ext as byte.
//   word: rdata, off ignored. Misalignment not checked (trapped upstream).
//   LWL: off0 {rdata[7:0],rt[23:0]}; 1 {rdata[15:0],rt[15:0]}; 2 {rdata[23:0],rt[7:0]}; 3 rdata.
//   LWR: off0 rdata; 1 {rt[31:24],rdata[31:8]}; 2 {rt[31:16],rdata[31:16]}; 3 {rt[31:8],rdata[31:24]}.
//   left_right!=0 overrides rsize. left_right=2'b11 treated as normal.
//  Latency: ALU op 1 cycle; load 1 cycle after rdata_valid. Throughput 1/cycle for ALU ops.
//  Reset mid-WAIT/DRAIN: immediate return to IDLE, outputs cleared; pending response is
//   the memory side's responsibility to cancel (shared reset).
// TESTING
//  1 ALU op aluAns=32'h1234_5678, wRegAddr=5 -> next cycle wb_valid=1, wData=32'h1234_5678, stall_req=0.
//  2 LB signExt=1 addr=..02, rdata=32'h0080_0000 after 3 cycles -> stall_req=1 for 3 cycles,
//    then wData=32'hFFFF_FF80; LBU same -> 32'h0000_0080.
//  3 LH addr=..02 rdata=32'h8001_1234 signExt=1 -> 32'hFFFF_8001; LW -> 32'h8001_1234.
//  4 LWL off=1 rt=32'hAABB_CCDD rdata=32'h1122_3344 -> 32'h3344_CCDD; LWR off=2 -> 32'hAABB_1122.
//  5 Flush in WAIT, rdata_valid 2 cycles later -> no wb_valid, stall_req held until rdata_valid,
//    IDLE next cycle; following ALU op writes back normally.
//  6 Back-to-back ALU ops 4 cycles -> 4 consecutive wb_valid; aresetn pulse in WAIT -> all outputs 0.

Source files
------------

// File: rtl/mem_wb_load_unit_if.sv
// MEM->WB field bundle, read response and writeback bus
// for the WB-stage load unit.
interface mem_wb_load_unit_if;
  logic        flush;
  logic        in_valid;
  logic        in_wRegEn;
  logic [4:0]  in_wRegAddr;
  logic [31:0] in_aluAns;
  logic        in_rwmem;
  logic [2:0]  in_rsize;
  logic        in_signExt;
  logic [1:0]  in_left_right;
  logic [31:0] in_rtReg;
  logic [31:0] in_pc;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        stall_req;
  logic        wb_valid;
  logic        wb_wRegEn;
  logic [4:0]  wb_wRegAddr;
  logic [31:0] wb_wData;
  logic [31:0] wb_pc;

  modport master (
    output flush, in_valid, in_wRegEn, in_wRegAddr,
    output in_aluAns, in_rwmem, in_rsize, in_signExt,
    output in_left_right, in_rtReg, in_pc,
    output rdata_valid, rdata,
    input  stall_req, wb_valid, wb_wRegEn,
    input  wb_wRegAddr, wb_wData, wb_pc
  );

  modport slave (
    input  flush, in_valid, in_wRegEn, in_wRegAddr,
    input  in_aluAns, in_rwmem, in_rsize, in_signExt,
    input  in_left_right, in_rtReg, in_pc,
    input  rdata_valid, rdata,
    output stall_req, wb_valid, wb_wRegEn,
    output wb_wRegAddr, wb_wData, wb_pc
  );
endinterface

// File: rtl/mem_wb_load_unit.sv
// WB-stage unit: passes ALU results through, waits for load
// data, then aligns/extends/merges it into GPR write data.
module mem_wb_load_unit (
  input  logic                clk,
  input  logic                aresetn,
  mem_wb_load_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_acc_alu;
  logic        w_acc_ld;
  logic        w_wb_ld;

  logic [1:0]  r_off;
  logic [2:0]  r_rsize;
  logic        r_sext;
  logic [1:0]  r_lr;
  logic [31:0] r_rt;
  logic        r_wen;
  logic [4:0]  r_waddr;
  logic [31:0] r_pc;

  logic        r_wb_valid;
  logic        r_wb_wen;
  logic [4:0]  r_wb_waddr;
  logic [31:0] r_wb_wdata;
  logic [31:0] r_wb_pc;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_norm;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;
  logic [31:0] w_align;

  always_comb begin
    w_next    = r_state;
    w_acc_alu = 1'b0;
    w_acc_ld  = 1'b0;
    w_wb_ld   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          if (bus.in_rwmem) begin
            w_acc_ld = 1'b1;
            w_next   = S_WAIT;
          end else begin
            w_acc_alu = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (bus.rdata_valid) begin
          w_wb_ld = !bus.flush;
          w_next  = S_IDLE;
        end else if (bus.flush) begin
          // response still owed by memory; swallow it later
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.rdata_valid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte = bus.rdata[7:0];
    w_lwl  = bus.rdata;
    w_lwr  = bus.rdata;
    unique case (r_off)
      2'd0: begin
        w_byte = bus.rdata[7:0];
        w_lwl  = {bus.rdata[7:0], r_rt[23:0]};
        w_lwr  = bus.rdata;
      end
      2'd1: begin
        w_byte = bus.rdata[15:8];
        w_lwl  = {bus.rdata[15:0], r_rt[15:0]};
        w_lwr  = {r_rt[31:24], bus.rdata[31:8]};
      end
      2'd2: begin
        w_byte = bus.rdata[23:16];
        w_lwl  = {bus.rdata[23:0], r_rt[7:0]};
        w_lwr  = {r_rt[31:16], bus.rdata[31:16]};
      end
      default: begin
        w_byte = bus.rdata[31:24];
        w_lwl  = bus.rdata;
        w_lwr  = {r_rt[31:8], bus.rdata[31:24]};
      end
    endcase
    w_half = r_off[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    unique case (r_rsize)
      3'd1:    w_norm = {{24{r_sext & w_byte[7]}}, w_byte};
      3'd2:    w_norm = {{16{r_sext & w_half[15]}}, w_half};
      default: w_norm = bus.rdata;
    endcase
    unique case (r_lr)
      2'b01:   w_align = w_lwl;
      2'b10:   w_align = w_lwr;
      default: w_align = w_norm;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_off      <= '0;
      r_rsize    <= '0;
      r_sext     <= 1'b0;
      r_lr       <= '0;
      r_rt       <= '0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_pc       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_wen   <= 1'b0;
      r_wb_waddr <= '0;
      r_wb_wdata <= '0;
      r_wb_pc    <= '0;
    end else begin
      r_state    <= w_next;
      r_wb_valid <= w_acc_alu | w_wb_ld;
      r_wb_wen   <= (w_acc_alu & bus.in_wRegEn) | (w_wb_ld & r_wen);
      if (w_acc_alu) begin
        r_wb_waddr <= bus.in_wRegAddr;
        r_wb_wdata <= bus.in_aluAns;
        r_wb_pc    <= bus.in_pc;
      end
      if (w_wb_ld) begin
        r_wb_waddr <= r_waddr;
        r_wb_wdata <= w_align;
        r_wb_pc    <= r_pc;
      end
      if (w_acc_ld) begin
        r_off   <= bus.in_aluAns[1:0];
        r_rsize <= bus.in_rsize;
        r_sext  <= bus.in_signExt;
        r_lr    <= bus.in_left_right;
        r_rt    <= bus.in_rtReg;
        r_wen   <= bus.in_wRegEn;
        r_waddr <= bus.in_wRegAddr;
        r_pc    <= bus.in_pc;
      end
    end
  end

  assign bus.stall_req   = (r_state != S_IDLE);
  assign bus.wb_valid    = r_wb_valid;
  assign bus.wb_wRegEn   = r_wb_wen;
  assign bus.wb_wRegAddr = r_wb_waddr;
  assign bus.wb_wData    = r_wb_wdata;
  assign bus.wb_pc       = r_wb_pc;

endmodule

// File: tb/tb_mem_wb_load_unit.sv
// Directed bench for mem_wb_load_unit: load alignment table
// plus hand sequences for flush, drain, reset and ALU streaming.
module tb_mem_wb_load_unit;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  mem_wb_load_unit_if b ();

  mem_wb_load_unit dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (b.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rsize;
    logic        sext;
    logic [1:0]  lr;
    logic [1:0]  off;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    b.flush         = 1'b0;
    b.in_valid      = 1'b0;
    b.in_wRegEn     = 1'b0;
    b.in_wRegAddr   = '0;
    b.in_aluAns     = '0;
    b.in_rwmem      = 1'b0;
    b.in_rsize      = '0;
    b.in_signExt    = 1'b0;
    b.in_left_right = '0;
    b.in_rtReg      = '0;
    b.in_pc         = '0;
    b.rdata_valid   = 1'b0;
    b.rdata         = 32'hDEAD_BEEF;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] ans,
                           input logic [31:0] pc);
    b.in_valid    = 1'b1;
    b.in_rwmem    = 1'b0;
    b.in_wRegEn   = 1'b1;
    b.in_wRegAddr = rd;
    b.in_aluAns   = ans;
    b.in_pc       = pc;
  endtask

  task automatic drive_load(input vec_t v, input logic [4:0] rd,
                            input logic [31:0] pc);
    b.in_valid      = 1'b1;
    b.in_rwmem      = 1'b1;
    b.in_wRegEn     = 1'b1;
    b.in_wRegAddr   = rd;
    b.in_aluAns     = {30'h0400_0000, v.off};
    b.in_rsize      = v.rsize;
    b.in_signExt    = v.sext;
    b.in_left_right = v.lr;
    b.in_rtReg      = v.rt;
    b.in_pc         = pc;
  endtask

  task automatic run_load(input vec_t v, input int dly, input int id);
    string nm;
    logic [4:0]  rd;
    logic [31:0] pc;
    nm = $sformatf("vec%0d", id);
    rd = 5'(id + 3);
    pc = 32'h0000_1000 + 32'(id * 4);
    drive_load(v, rd, pc);
    tick();
    clr_in();
    for (int k = 0; k < dly; k++) begin
      chk({nm, " stall"}, 32'(b.stall_req), 32'd1);
      chk({nm, " wbv_wait"}, 32'(b.wb_valid), 32'd0);
      if (k == dly - 1) begin
        b.rdata_valid = 1'b1;
        b.rdata       = v.rdata;
      end
      tick();
    end
    clr_in();
    chk({nm, " wbv"}, 32'(b.wb_valid), 32'd1);
    chk({nm, " data"}, b.wb_wData, v.exp);
    chk({nm, " addr"}, 32'(b.wb_wRegAddr), 32'(rd));
    chk({nm, " wen"}, 32'(b.wb_wRegEn), 32'd1);
    chk({nm, " pc"}, b.wb_pc, pc);
    chk({nm, " stall_done"}, 32'(b.stall_req), 32'd0);
    tick();
    chk({nm, " wbv_after"}, 32'(b.wb_valid), 32'd0);
  endtask

  initial begin
    vec_t lw;
    tv[0]  = '{3'd1, 1'b1, 2'b00, 2'd2, 32'h0, 32'h0080_0000, 32'hFFFF_FF80};
    tv[1]  = '{3'd1, 1'b0, 2'b00, 2'd2, 32'h0, 32'h0080_0000, 32'h0000_0080};
    tv[2]  = '{3'd2, 1'b1, 2'b00, 2'd2, 32'h0, 32'h8001_1234, 32'hFFFF_8001};
    tv[3]  = '{3'd4, 1'b0, 2'b00, 2'd2, 32'h0, 32'h8001_1234, 32'h8001_1234};
    tv[4]  = '{3'd4, 1'b0, 2'b01, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD};
    tv[5]  = '{3'd4, 1'b0, 2'b10, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122};
    tv[6]  = '{3'd1, 1'b0, 2'b00, 2'd0, 32'h0, 32'h1122_33F4, 32'h0000_00F4};
    tv[7]  = '{3'd1, 1'b1, 2'b00, 2'd3, 32'h0, 32'h8522_3344, 32'hFFFF_FF85};
    tv[8]  = '{3'd2, 1'b1, 2'b00, 2'd0, 32'h0, 32'h1122_F344, 32'hFFFF_F344};
    tv[9]  = '{3'd2, 1'b0, 2'b00, 2'd3, 32'h0, 32'h8001_1234, 32'h0000_8001};
    tv[10] = '{3'd4, 1'b0, 2'b01, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD};
    tv[11] = '{3'd4, 1'b0, 2'b01, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344};
    tv[12] = '{3'd4, 1'b0, 2'b10, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344};
    tv[13] = '{3'd4, 1'b0, 2'b10, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11};
    tv[14] = '{3'd1, 1'b1, 2'b01, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'h2233_44DD};
    tv[15] = '{3'd2, 1'b1, 2'b10, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233};
    tv[16] = '{3'd1, 1'b0, 2'b11, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h0000_0033};

    clr_in();
    #12;
    chk("rst stall", 32'(b.stall_req), 32'd0);
    chk("rst wbv", 32'(b.wb_valid), 32'd0);
    chk("rst wen", 32'(b.wb_wRegEn), 32'd0);
    chk("rst addr", 32'(b.wb_wRegAddr), 32'd0);
    chk("rst data", b.wb_wData, 32'd0);
    chk("rst pc", b.wb_pc, 32'd0);
    aresetn = 1'b1;
    tick();

    // single ALU op
    drive_alu(5'd5, 32'h1234_5678, 32'h0000_0100);
    tick();
    clr_in();
    chk("alu wbv", 32'(b.wb_valid), 32'd1);
    chk("alu data", b.wb_wData, 32'h1234_5678);
    chk("alu addr", 32'(b.wb_wRegAddr), 32'd5);
    chk("alu wen", 32'(b.wb_wRegEn), 32'd1);
    chk("alu pc", b.wb_pc, 32'h0000_0100);
    chk("alu stall", 32'(b.stall_req), 32'd0);
    tick();
    chk("alu wbv_after", 32'(b.wb_valid), 32'd0);
    chk("alu wen_after", 32'(b.wb_wRegEn), 32'd0);

    // load alignment table
    for (int i = 0; i < 17; i++)
      run_load(tv[i], (i % 3) + 1, i);

    // flush in WAIT, extra flush in DRAIN, response 2 cycles later
    drive_load(tv[3], 5'd9, 32'h0000_2000);
    tick();
    clr_in();
    b.flush = 1'b1;
    tick();
    chk("fl stall0", 32'(b.stall_req), 32'd1);
    chk("fl wbv0", 32'(b.wb_valid), 32'd0);
    tick();
    b.flush = 1'b0;
    chk("fl stall1", 32'(b.stall_req), 32'd1);
    b.rdata_valid = 1'b1;
    b.rdata = 32'h5555_AAAA;
    tick();
    clr_in();
    chk("fl wbv", 32'(b.wb_valid), 32'd0);
    chk("fl stall_done", 32'(b.stall_req), 32'd0);
    drive_alu(5'd7, 32'hCAFE_0001, 32'h0000_2004);
    tick();
    clr_in();
    chk("fl alu wbv", 32'(b.wb_valid), 32'd1);
    chk("fl alu data", b.wb_wData, 32'hCAFE_0001);

    // flush together with response in WAIT
    drive_load(tv[3], 5'd10, 32'h0000_3000);
    tick();
    clr_in();
    b.flush = 1'b1;
    b.rdata_valid = 1'b1;
    tick();
    clr_in();
    chk("flrv wbv", 32'(b.wb_valid), 32'd0);
    chk("flrv stall", 32'(b.stall_req), 32'd0);

    // flush in acceptance cycle kills the instruction
    drive_alu(5'd11, 32'h0BAD_0BAD, 32'h0000_3004);
    b.flush = 1'b1;
    tick();
    clr_in();
    chk("flacc wbv", 32'(b.wb_valid), 32'd0);
    chk("flacc data", b.wb_wData, 32'hCAFE_0001);

    // stray response in IDLE
    b.rdata_valid = 1'b1;
    tick();
    clr_in();
    chk("idle rv wbv", 32'(b.wb_valid), 32'd0);
    chk("idle rv stall", 32'(b.stall_req), 32'd0);

    // back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      drive_alu(5'(12 + i), 32'hA000_0000 + 32'(i), 32'h0000_4000 + 32'(4 * i));
      tick();
      chk($sformatf("b2b%0d wbv", i), 32'(b.wb_valid), 32'd1);
      chk($sformatf("b2b%0d data", i), b.wb_wData, 32'hA000_0000 + 32'(i));
      chk($sformatf("b2b%0d addr", i), 32'(b.wb_wRegAddr), 32'(12 + i));
    end
    clr_in();
    tick();
    chk("b2b end wbv", 32'(b.wb_valid), 32'd0);

    // async reset pulse while in WAIT
    lw = tv[3];
    drive_load(lw, 5'd20, 32'h0000_5000);
    tick();
    clr_in();
    chk("rw stall", 32'(b.stall_req), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("rw stall_rst", 32'(b.stall_req), 32'd0);
    chk("rw wbv", 32'(b.wb_valid), 32'd0);
    chk("rw wen", 32'(b.wb_wRegEn), 32'd0);
    chk("rw addr", 32'(b.wb_wRegAddr), 32'd0);
    chk("rw data", b.wb_wData, 32'd0);
    chk("rw pc", b.wb_pc, 32'd0);
    #1;
    aresetn = 1'b1;
    tick();
    b.rdata_valid = 1'b1;
    b.rdata = 32'h7777_7777;
    tick();
    clr_in();
    chk("rw post wbv", 32'(b.wb_valid), 32'd0);
    chk("rw post stall", 32'(b.stall_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
